// File: rtl/control_sequencer.sv
// control_sequencer: hardwired T-state control unit for the single-bus DataPath.
// Fetch in T0-T2, opcode-driven execute in T3-T7, HALT until clear.
module control_sequencer #(
  parameter logic [4:0] ALU_INC = 5'b11111,
  parameter logic [4:0] ALU_ADD = 5'b00011
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [4:0] opcode,
  input  logic       ConOut,
  input  logic       stop,
  output logic       HiIn,
  output logic       LoIn,
  output logic       ZIn,
  output logic       PCIn,
  output logic       MDRIn,
  output logic       MARIn,
  output logic       YIn,
  output logic       OPortIn,
  output logic       IRIn,
  output logic       HiOut,
  output logic       LoOut,
  output logic       ZHiOut,
  output logic       ZLoOut,
  output logic       PCOut,
  output logic       MDROut,
  output logic       IPortOut,
  output logic       COut,
  output logic       Gra,
  output logic       Grb,
  output logic       Grc,
  output logic       RIn,
  output logic       ROut,
  output logic       BAOut,
  output logic       Conin,
  output logic       memread,
  output logic       memwrite,
  output logic [4:0] ALUCode,
  output logic       run
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t state_q, state_d, last_s;

  logic is_alu3, is_imm, is_mdiv, is_un;
  logic is_ld, is_ldi, is_st, is_br;
  logic is_jr, is_in, is_out, is_mfhi;
  logic is_mflo, is_halt;

  assign is_alu3 = (opcode >= 5'd3) && (opcode <= 5'd11);
  assign is_imm  = (opcode >= 5'd12) && (opcode <= 5'd14);
  assign is_mdiv = (opcode == 5'd15) || (opcode == 5'd16);
  assign is_un   = (opcode == 5'd17) || (opcode == 5'd18);
  assign is_ld   = (opcode == 5'd0);
  assign is_ldi  = (opcode == 5'd1);
  assign is_st   = (opcode == 5'd2);
  assign is_br   = (opcode == 5'd19);
  assign is_jr   = (opcode == 5'd20);
  assign is_in   = (opcode == 5'd22);
  assign is_out  = (opcode == 5'd23);
  assign is_mfhi = (opcode == 5'd24);
  assign is_mflo = (opcode == 5'd25);
  assign is_halt = (opcode == 5'd27);

  // Final T-state of the decoded instruction
  always_comb begin
    last_s = S_T2;
    unique case (1'b1)
      is_alu3, is_imm, is_ldi:  last_s = S_T5;
      is_mdiv, is_br:           last_s = S_T6;
      is_un:                    last_s = S_T4;
      is_ld, is_st:             last_s = S_T7;
      is_jr, is_in, is_out,
      is_mfhi, is_mflo:         last_s = S_T3;
      default:                  last_s = S_T2;
    endcase
  end

  // Next state: step, wrap to T0, or divert to HALT
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET: state_d = stop ? S_HALT : S_T0;
      S_HALT:  state_d = S_HALT;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      default: begin
        if (state_q == S_T2 && is_halt)
          state_d = S_HALT;
        else if (state_q >= last_s)
          state_d = stop ? S_HALT : S_T0;
        else
          state_d = state_t'(state_q + 4'd1);
      end
    endcase
  end

  // State register, aborts instantly on clear
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  // Control word decode from state, opcode and ConOut
  always_comb begin
    HiIn = 1'b0; LoIn = 1'b0; ZIn = 1'b0;
    PCIn = 1'b0; MDRIn = 1'b0; MARIn = 1'b0;
    YIn = 1'b0; OPortIn = 1'b0; IRIn = 1'b0;
    HiOut = 1'b0; LoOut = 1'b0; ZHiOut = 1'b0;
    ZLoOut = 1'b0; PCOut = 1'b0; MDROut = 1'b0;
    IPortOut = 1'b0; COut = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    RIn = 1'b0; ROut = 1'b0; BAOut = 1'b0;
    Conin = 1'b0; memread = 1'b0; memwrite = 1'b0;
    ALUCode = 5'd0;
    run = (state_q != S_HALT);
    unique case (state_q)
      S_T0: begin
        PCOut = 1'b1; MARIn = 1'b1; ZIn = 1'b1;
        ALUCode = ALU_INC;
      end
      S_T1: begin
        ZLoOut = 1'b1; PCIn = 1'b1;
        memread = 1'b1; MDRIn = 1'b1;
      end
      S_T2: begin
        MDROut = 1'b1; IRIn = 1'b1;
      end
      S_T3: begin
        unique case (1'b1)
          is_alu3, is_imm: begin
            Grb = 1'b1; ROut = 1'b1; YIn = 1'b1;
          end
          is_mdiv: begin
            Gra = 1'b1; ROut = 1'b1; YIn = 1'b1;
          end
          is_un: begin
            Grb = 1'b1; ROut = 1'b1; ZIn = 1'b1;
            ALUCode = opcode;
          end
          is_ld, is_ldi, is_st: begin
            Grb = 1'b1; BAOut = 1'b1; YIn = 1'b1;
          end
          is_br: begin
            Gra = 1'b1; ROut = 1'b1; Conin = 1'b1;
          end
          is_jr: begin
            Gra = 1'b1; ROut = 1'b1; PCIn = 1'b1;
          end
          is_in: begin
            IPortOut = 1'b1; Gra = 1'b1; RIn = 1'b1;
          end
          is_out: begin
            Gra = 1'b1; ROut = 1'b1; OPortIn = 1'b1;
          end
          is_mfhi: begin
            HiOut = 1'b1; Gra = 1'b1; RIn = 1'b1;
          end
          is_mflo: begin
            LoOut = 1'b1; Gra = 1'b1; RIn = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        unique case (1'b1)
          is_alu3: begin
            Grc = 1'b1; ROut = 1'b1; ZIn = 1'b1;
            ALUCode = opcode;
          end
          is_imm: begin
            COut = 1'b1; ZIn = 1'b1;
            ALUCode = opcode;
          end
          is_mdiv: begin
            Grb = 1'b1; ROut = 1'b1; ZIn = 1'b1;
            ALUCode = opcode;
          end
          is_un: begin
            ZLoOut = 1'b1; Gra = 1'b1; RIn = 1'b1;
          end
          is_ld, is_ldi, is_st: begin
            COut = 1'b1; ZIn = 1'b1;
            ALUCode = ALU_ADD;
          end
          is_br: begin
            PCOut = 1'b1; YIn = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        unique case (1'b1)
          is_alu3, is_imm, is_ldi: begin
            ZLoOut = 1'b1; Gra = 1'b1; RIn = 1'b1;
          end
          is_mdiv: begin
            ZLoOut = 1'b1; LoIn = 1'b1;
          end
          is_ld, is_st: begin
            ZLoOut = 1'b1; MARIn = 1'b1;
          end
          is_br: begin
            COut = 1'b1; ZIn = 1'b1;
            ALUCode = ALU_ADD;
          end
          default: ;
        endcase
      end
      S_T6: begin
        unique case (1'b1)
          is_mdiv: begin
            ZHiOut = 1'b1; HiIn = 1'b1;
          end
          is_ld: begin
            memread = 1'b1; MDRIn = 1'b1;
          end
          is_st: begin
            Gra = 1'b1; ROut = 1'b1; MDRIn = 1'b1;
          end
          is_br: begin
            ZLoOut = ConOut; PCIn = ConOut;
          end
          default: ;
        endcase
      end
      S_T7: begin
        unique case (1'b1)
          is_ld: begin
            MDROut = 1'b1; Gra = 1'b1; RIn = 1'b1;
          end
          is_st: memwrite = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: random and directed instruction streams checked
// every cycle against an instruction-level step-list model.
module tb_control_sequencer;

  logic clock, clear, ConOut, stop;
  logic [4:0] opcode, ALUCode;
  logic HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn;
  logic HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut;
  logic Gra, Grb, Grc, RIn, ROut, BAOut, Conin, memread, memwrite, run;

  control_sequencer dut (
    .clock(clock), .clear(clear), .opcode(opcode), .ConOut(ConOut),
    .stop(stop), .HiIn(HiIn), .LoIn(LoIn), .ZIn(ZIn), .PCIn(PCIn),
    .MDRIn(MDRIn), .MARIn(MARIn), .YIn(YIn), .OPortIn(OPortIn),
    .IRIn(IRIn), .HiOut(HiOut), .LoOut(LoOut), .ZHiOut(ZHiOut),
    .ZLoOut(ZLoOut), .PCOut(PCOut), .MDROut(MDROut),
    .IPortOut(IPortOut), .COut(COut), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .RIn(RIn), .ROut(ROut), .BAOut(BAOut), .Conin(Conin),
    .memread(memread), .memwrite(memwrite), .ALUCode(ALUCode), .run(run)
  );

  typedef struct packed {
    logic        r;
    logic [25:0] c;
    logic [4:0]  a;
  } word_t;
  typedef word_t wq_t[$];
  typedef enum {M_RST, M_RUN, M_HLT} mmode_t;

  localparam logic [25:0] HIIN = 26'd1 << 25, LOIN = 26'd1 << 24;
  localparam logic [25:0] ZIN = 26'd1 << 23, PCIN = 26'd1 << 22;
  localparam logic [25:0] MDRIN = 26'd1 << 21, MARIN = 26'd1 << 20;
  localparam logic [25:0] YIN = 26'd1 << 19, OPIN = 26'd1 << 18;
  localparam logic [25:0] IRIN = 26'd1 << 17, HIOUT = 26'd1 << 16;
  localparam logic [25:0] LOOUT = 26'd1 << 15, ZHIOUT = 26'd1 << 14;
  localparam logic [25:0] ZLOOUT = 26'd1 << 13, PCOUT = 26'd1 << 12;
  localparam logic [25:0] MDROUT = 26'd1 << 11, IPOUT = 26'd1 << 10;
  localparam logic [25:0] COUT = 26'd1 << 9, GRA = 26'd1 << 8;
  localparam logic [25:0] GRB = 26'd1 << 7, GRC = 26'd1 << 6;
  localparam logic [25:0] RIN = 26'd1 << 5, ROUT = 26'd1 << 4;
  localparam logic [25:0] BAOUT = 26'd1 << 3, CONIN = 26'd1 << 2;
  localparam logic [25:0] MRD = 26'd1 << 1, MWR = 26'd1;
  localparam logic [4:0]  A_INC = 5'b11111, A_ADD = 5'b00011;

  word_t dut_w;
  assign dut_w = {run, HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn,
                  IRIn, HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut,
                  IPortOut, COut, Gra, Grb, Grc, RIn, ROut, BAOut, Conin,
                  memread, memwrite, ALUCode};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic word_t mk(input logic [25:0] c, input logic [4:0] a);
    return {1'b1, c, a};
  endfunction

  // Execute step list of an instruction (T3 onward)
  function automatic wq_t prog(input logic [4:0] op, input logic con);
    wq_t s;
    s = {};
    if (op inside {[5'd3:5'd11]}) begin
      s.push_back(mk(GRB | ROUT | YIN, 5'd0));
      s.push_back(mk(GRC | ROUT | ZIN, op));
      s.push_back(mk(ZLOOUT | GRA | RIN, 5'd0));
    end else if (op inside {[5'd12:5'd14]}) begin
      s.push_back(mk(GRB | ROUT | YIN, 5'd0));
      s.push_back(mk(COUT | ZIN, op));
      s.push_back(mk(ZLOOUT | GRA | RIN, 5'd0));
    end else if (op inside {5'd15, 5'd16}) begin
      s.push_back(mk(GRA | ROUT | YIN, 5'd0));
      s.push_back(mk(GRB | ROUT | ZIN, op));
      s.push_back(mk(ZLOOUT | LOIN, 5'd0));
      s.push_back(mk(ZHIOUT | HIIN, 5'd0));
    end else if (op inside {5'd17, 5'd18}) begin
      s.push_back(mk(GRB | ROUT | ZIN, op));
      s.push_back(mk(ZLOOUT | GRA | RIN, 5'd0));
    end else if (op inside {5'd0, 5'd1, 5'd2}) begin
      s.push_back(mk(GRB | BAOUT | YIN, 5'd0));
      s.push_back(mk(COUT | ZIN, A_ADD));
      if (op == 5'd1) begin
        s.push_back(mk(ZLOOUT | GRA | RIN, 5'd0));
      end else begin
        s.push_back(mk(ZLOOUT | MARIN, 5'd0));
        if (op == 5'd0) begin
          s.push_back(mk(MRD | MDRIN, 5'd0));
          s.push_back(mk(MDROUT | GRA | RIN, 5'd0));
        end else begin
          s.push_back(mk(GRA | ROUT | MDRIN, 5'd0));
          s.push_back(mk(MWR, 5'd0));
        end
      end
    end else if (op == 5'd19) begin
      s.push_back(mk(GRA | ROUT | CONIN, 5'd0));
      s.push_back(mk(PCOUT | YIN, 5'd0));
      s.push_back(mk(COUT | ZIN, A_ADD));
      s.push_back(mk(con ? (ZLOOUT | PCIN) : 26'd0, 5'd0));
    end else if (op == 5'd20) begin
      s.push_back(mk(GRA | ROUT | PCIN, 5'd0));
    end else if (op == 5'd22) begin
      s.push_back(mk(IPOUT | GRA | RIN, 5'd0));
    end else if (op == 5'd23) begin
      s.push_back(mk(GRA | ROUT | OPIN, 5'd0));
    end else if (op == 5'd24) begin
      s.push_back(mk(HIOUT | GRA | RIN, 5'd0));
    end else if (op == 5'd25) begin
      s.push_back(mk(LOOUT | GRA | RIN, 5'd0));
    end
    return s;
  endfunction

  mmode_t m_mode = M_RST;
  int m_k = 0;
  wq_t mq, cq;

  // Model: instruction step counter
  always @(posedge clock or negedge clear) begin
    if (!clear) begin
      m_mode = M_RST;
      m_k = 0;
    end else begin
      case (m_mode)
        M_RST: begin
          m_mode = stop ? M_HLT : M_RUN;
          m_k = 0;
        end
        M_RUN: begin
          mq = prog(opcode, ConOut);
          if (m_k == 2 && opcode == 5'd27) m_mode = M_HLT;
          else if (m_k >= 2 && m_k == 2 + mq.size()) begin
            if (stop) m_mode = M_HLT;
            else m_k = 0;
          end else m_k++;
        end
        default: ;
      endcase
    end
  end

  // Every-cycle compare against the model
  always @(negedge clock) begin
    word_t e;
    e = '0;
    if (m_mode == M_RST) e.r = 1'b1;
    else if (m_mode == M_RUN) begin
      if (m_k == 0) e = mk(PCOUT | MARIN | ZIN, A_INC);
      else if (m_k == 1) e = mk(ZLOOUT | PCIN | MRD | MDRIN, 5'd0);
      else if (m_k == 2) e = mk(MDROUT | IRIN, 5'd0);
      else begin
        cq = prog(opcode, ConOut);
        if (m_k - 3 < cq.size()) e = cq[m_k - 3];
      end
    end
    chk("cycle", dut_w, e);
    if (memread && memwrite) chk("mem_excl", 32'd1, 32'd0);
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Runs one instruction starting in T0; len counts cycles to the next T0/HALT
  task automatic do_instr(input logic [4:0] op, input logic con,
                          input int stp_at, output int len);
    int k;
    bit done;
    k = 0;
    done = 0;
    opcode = 5'($urandom);
    ConOut = con;
    stop = (stp_at == 0);
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clock);
      #2;
      k++;
      if (!run || (PCOut && MARIn && ZIn)) done = 1;
      else begin
        opcode = (k >= 2) ? op : 5'($urandom);
        if (stp_at >= 0 && k >= stp_at) stop = 1'b1;
      end
    end
    if (!done) chk("instr_timeout", 32'd0, 32'd1);
    len = k;
    stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b0;
    #1;
    clear = 1'b1;
    @(posedge clock);
    #2;
  endtask

  int len, hc, stp;
  logic [4:0] rop;
  logic rcon;

  initial begin
    clear = 1'b1;
    stop = 1'b0;
    opcode = 5'd0;
    ConOut = 1'b0;
    #1 clear = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    chk("reset_idle", dut_w, {1'b1, 26'd0, 5'd0});
    clear = 1'b1;
    @(posedge clock);
    #2;
    chk("first_t0", dut_w, mk(PCOUT | MARIN | ZIN, 5'b11111));

    do_instr(5'd3, 1'b0, -1, len);
    chk("add_len", len, 6);

    opcode = 5'($urandom);
    repeat (2) begin @(posedge clock); #2; end
    opcode = 5'd3;
    repeat (2) begin @(posedge clock); #2; end
    chk("add_t4", dut_w, mk(GRC | ROUT | ZIN, 5'b00011));
    clear = 1'b0;
    #1;
    chk("reset_mid", dut_w, {1'b1, 26'd0, 5'd0});
    clear = 1'b1;
    @(posedge clock);
    #2;
    chk("reset_t0", dut_w, mk(PCOUT | MARIN | ZIN, 5'b11111));

    do_instr(5'd19, 1'b1, -1, len); chk("br1_len", len, 7);
    do_instr(5'd19, 1'b0, -1, len); chk("br0_len", len, 7);
    do_instr(5'd0, 1'b0, -1, len);  chk("ld_len", len, 8);
    do_instr(5'd2, 1'b1, -1, len);  chk("st_len", len, 8);
    do_instr(5'd17, 1'b0, -1, len); chk("neg_len", len, 5);
    do_instr(5'd24, 1'b0, -1, len); chk("mfhi_len", len, 4);
    do_instr(5'd20, 1'b0, -1, len); chk("jr_len", len, 4);
    do_instr(5'd26, 1'b0, -1, len); chk("nop_len", len, 3);
    do_instr(5'd30, 1'b0, -1, len); chk("undef_len", len, 3);
    do_instr(5'd16, 1'b0, -1, len); chk("mul_len", len, 7);
    do_instr(5'd12, 1'b0, -1, len); chk("addi_len", len, 6);
    do_instr(5'd1, 1'b0, -1, len);  chk("ldi_len", len, 6);

    do_instr(5'd3, 1'b0, 4, len);
    chk("stop_len", len, 6);
    chk("stop_run", {31'd0, run}, 32'd0);
    pulse_clear();

    do_instr(5'd27, 1'b0, -1, len);
    chk("halt_len", len, 3);
    hc = 0;
    repeat (100) begin
      @(posedge clock);
      #2;
      if (!run && dut_w == '0) hc++;
    end
    chk("halt_hold", hc, 100);
    pulse_clear();
    chk("halt_exit", dut_w, mk(PCOUT | MARIN | ZIN, 5'b11111));

    repeat (400) begin
      rop = 5'($urandom);
      rcon = 1'($urandom);
      stp = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 7)) : -1;
      do_instr(rop, rcon, stp, len);
      if (!run) pulse_clear();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the 32-bit single-bus DataPath. It fetches each instruction, decodes the 5-bit opcode from IR[31:27], and steps through the T-state sequence for that instruction. In each state it drives the DataPath's register-enable, bus-select, memory, ALU-code and Gra/Grb/Grc/Conin control inputs. It replaces the hand-sequenced control that the phase-2 benches apply to DataPath.

## Interface
Parameters:
- ALU_INC, 5'b11111, ALUCode for PC increment during fetch
- ALU_ADD, 5'b00011, ALUCode for address and branch-target add

Ports:
- clock  input  1  system clock; the state register advances on the rising edge
- clear  input  1  asynchronous active-low reset
- opcode  input  5  IR[31:27], exported by DataPath
- ConOut  input  1  CON flip-flop output from DataPath
- stop  input  1  synchronous halt request, sampled at instruction boundary
- HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn  output  1 each  register load enables
- HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut  output  1 each  bus drivers
- Gra, Grb, Grc, RIn, ROut, BAOut, Conin  output  1 each  register-select and CON-load controls
- memread, memwrite  output  1 each  memory strobes
- ALUCode  output  5  ALU operation select
- run  output  1  high while executing; low in HALT

## Operation
- State register holds RESET, T0–T7, or HALT. All control outputs are pure combinational decode of (state, opcode, ConOut). Outputs not listed for a state are 0.
- Fetch (all instructions):
  - T0: PCOut, MARIn, ZIn, ALUCode=ALU_INC
  - T1: ZLoOut, PCIn, memread, MDRIn
  - T2: MDROut, IRIn
- Execute by opcode. The last listed state returns to T0.
  - add/sub/and/or/ror/rol/shr/shra/shl (00011–01011): T3 Grb ROut YIn; T4 Grc ROut ZIn ALUCode=opcode; T5 ZLoOut Gra RIn
  - addi/andi/ori (01100–01110): T3 Grb ROut YIn; T4 COut ZIn ALUCode=opcode; T5 ZLoOut Gra RIn
  - div/mul (01111, 10000): T3 Gra ROut YIn; T4 Grb ROut ZIn ALUCode=opcode; T5 ZLoOut LoIn; T6 ZHiOut HiIn
  - neg/not (10001, 10010): T3 Grb ROut ZIn ALUCode=opcode; T4 ZLoOut Gra RIn
  - ld (00000): T3 Grb BAOut YIn; T4 COut ZIn ALUCode=ALU_ADD; T5 ZLoOut MARIn; T6 memread MDRIn; T7 MDROut Gra RIn
  - ldi (00001): T3–T4 as ld; T5 ZLoOut Gra RIn
  - st (00010): T3–T5 as ld; T6 Gra ROut MDRIn; T7 memwrite
  - br (10011): T3 Gra ROut Conin; T4 PCOut YIn; T5 COut ZIn ALUCode=ALU_ADD; T6 ZLoOut and PCIn only if ConOut=1, otherwise T6 drives nothing
  - jr (10100): T3 Gra ROut PCIn
  - in (10110): T3 IPortOut Gra RIn
  - out (10111): T3 Gra ROut OPortIn
  - mfhi (11000): T3 HiOut Gra RIn
  - mflo (11001): T3 LoOut Gra RIn
  - nop (11010), jal (10101), and undefined opcodes (11100–11111): T2 → T0; no execute states
  - halt (11011): T2 → HALT
- HALT: all control outputs 0 and run=0. Only clear exits HALT.
- stop: on any edge where the next state would be T0, stop=1 sends the sequencer to HALT instead. The current instruction always completes.

## Timing
- One state per clock. DataPath loads at the rising edge that ends the state.
- While clear=0, state=RESET: all control outputs 0, ALUCode=0, run=1. The first rising edge after clear goes high enters T0.
- Reset mid-instruction aborts immediately, asynchronously, with no completion of the remaining states.
- Instruction length, fetch included:
  - 4 cycles: jr, in, out, mfhi, mflo
  - 3 cycles: nop, undefined opcodes
  - 5 cycles: neg, not
  - 6 cycles: ldi and the 3-operand and immediate ALU ops
  - 7 cycles: br, mul, div
  - 8 cycles: ld, st
- opcode is sampled only in states T2 and later. Its value during T0–T1 is don't-care.
- ConOut is used only in br T6. It is valid because Conin loaded the CON flip-flop at the end of T3.
- memread and memwrite are never asserted in the same cycle.

## Test plan
- Reset mid-op: clear=0 during T4 of add → all outputs 0 in the same cycle and run=1. After release, the first cycle shows PCOut=MARIn=ZIn=1 with ALUCode=5'b11111.
- add, opcode 00011 → six cycles T0–T5. T4 has Grc=ROut=ZIn=1 with ALUCode=00011. T5 has ZLoOut=Gra=RIn=1. The seventh cycle is T0.
- br: with ConOut=1, T6 has ZLoOut=PCIn=1 and T5 has ALUCode=00011. Repeat with ConOut=0 → T6 drives all outputs 0. Both cases take 7 cycles.
- ld then st: ld T6 has memread=MDRIn=1 and T7 has MDROut=Gra=RIn=1. st T6 has Gra=ROut=MDRIn=1 and T7 has memwrite=1 only. Both take 8 cycles.
- halt, opcode 11011: the cycle after T2 shows run=0 and all outputs 0, held for 100 cycles. Pulsing clear low then restores T0.
- stop=1 asserted during T4 of add → T5 completes normally, then HALT with run=0. No T0 occurs.
